// File: rtl/seg_ram_disp.sv
// ---------------------------------------------------------------------------
// seg_ram_disp
//   Display stage for the RAM demo. Shows the RAM read address (left three
//   digits) and the RAM read data (right three digits) in decimal on a
//   6-digit common-anode seven-segment display using multiplexed scanning.
//   A free-running sequential double-dabble converter (LOAD, 8x SHIFT, DONE;
//   10-cycle period) turns both binary values into BCD in parallel. The
//   results are copied atomically into the display registers.
//
//   Parameters
//     SCAN_CNT_MAX : clock cycles per digit slot minus one.
//
//   Ports
//     sys_clk : system clock, rising edge.
//     rst_n   : asynchronous active-low reset.
//     addr    : RAM read address, binary 0-255.
//     data    : RAM read data q, binary 0-255.
//     sel     : digit select, active low, one-hot-low; sel[5] = leftmost.
//     seg     : segments, active low; seg[7] = dp, seg[6:0] = g..a.
//
//   Optional feature macro: SEG_LEAD_ZERO_BLANK_EN
//     When defined, leading zeros of each 3-digit group are blanked
//     (units digit and decimal point always shown).
// ---------------------------------------------------------------------------
module seg_ram_disp #(
  parameter logic [15:0] SCAN_CNT_MAX = 16'd49_999
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        load_en, shift_en, done_en;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  a_bin_q, a_bin_d, d_bin_q, d_bin_d;
  logic [11:0] a_bcd_q, a_bcd_d, d_bcd_q, d_bcd_d;
  logic [11:0] a_adj, d_adj;
  logic [11:0] a_disp_q, a_disp_d, d_disp_q, d_disp_d;

  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  dig_q, dig_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;

  logic [11:0] grp;
  logic [2:0]  pos;
  logic [3:0]  nib;
  logic        blank;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low segment code, dp off; non-decimal nibbles show blank.
  function automatic logic [7:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Converter FSM: state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Converter FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == 3'd7) state_d = ST_DONE;
      ST_DONE:  state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Converter FSM: control outputs
  always_comb begin
    load_en  = (state_q == ST_LOAD);
    shift_en = (state_q == ST_SHIFT);
    done_en  = (state_q == ST_DONE);
  end

  assign a_adj = add3(a_bcd_q);
  assign d_adj = add3(d_bcd_q);

  // Converter datapath
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    a_bin_d   = a_bin_q;
    d_bin_d   = d_bin_q;
    a_bcd_d   = a_bcd_q;
    d_bcd_d   = d_bcd_q;
    a_disp_d  = a_disp_q;
    d_disp_d  = d_disp_q;
    if (load_en) begin
      a_bin_d   = addr;
      d_bin_d   = data;
      a_bcd_d   = '0;
      d_bcd_d   = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      {a_bcd_d, a_bin_d} = {a_adj[10:0], a_bin_q, 1'b0};
      {d_bcd_d, d_bin_d} = {d_adj[10:0], d_bin_q, 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // Both groups update together so the display never mixes conversions.
    if (done_en) begin
      a_disp_d = a_bcd_q;
      d_disp_d = d_bcd_q;
    end
  end

  // Scan counter, digit selection and segment encoding
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    dig_d      = dig_q;
    if (scan_cnt_q == SCAN_CNT_MAX) begin
      scan_cnt_d = '0;
      dig_d      = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
    end

    grp   = (dig_q < 3'd3) ? a_disp_q : d_disp_q;
    pos   = (dig_q < 3'd3) ? dig_q : dig_q - 3'd3;
    blank = 1'b0;
    case (pos)
      3'd0:    nib = grp[11:8];
      3'd1:    nib = grp[7:4];
      default: nib = grp[3:0];
    endcase
`ifdef SEG_LEAD_ZERO_BLANK_EN
    if ((pos == 3'd0) && (grp[11:8] == 4'd0)) blank = 1'b1;
    if ((pos == 3'd1) && (grp[11:4] == 8'd0)) blank = 1'b1;
`endif

    sel_d = ~(6'b100000 >> dig_q);
    seg_d = blank ? 8'hFF : seg_code(nib);
    // The dp on digit 2 separates address from data.
    if (dig_q == 3'd2) seg_d[7] = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      a_bin_q    <= '0;
      d_bin_q    <= '0;
      a_bcd_q    <= '0;
      d_bcd_q    <= '0;
      a_disp_q   <= '0;
      d_disp_q   <= '0;
      scan_cnt_q <= '0;
      dig_q      <= '0;
      sel_q      <= 6'b111111;
      seg_q      <= 8'hFF;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      a_bin_q    <= a_bin_d;
      d_bin_q    <= d_bin_d;
      a_bcd_q    <= a_bcd_d;
      d_bcd_q    <= d_bcd_d;
      a_disp_q   <= a_disp_d;
      d_disp_q   <= d_disp_d;
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_ram_disp.sv
module tb_seg_ram_disp;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] data;
  logic [5:0] sel;
  logic [7:0] seg;

  seg_ram_disp #(.SCAN_CNT_MAX(16'd9)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data    (data),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    int         tag;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [5:0] sel_tab [0:5];
  // Expected segment codes per digit slot for each displayed value pair:
  // 0: 000/000  1: 100/255  2: 100/007  3: 005/040  4: 200/040
  logic [7:0] pats [0:4][0:5];

  task automatic push(input logic [5:0] s, input logic [7:0] g, input int tag);
    exp_t e;
    e.sel = s;
    e.seg = g;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_scan(input int k, input int p, input int tag);
    int slot;
    slot = ((k - 1) / 10) % 6;
    push(sel_tab[slot], pats[p][slot], tag);
  endtask

  // Monitor: compares whatever the DUT shows against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (sel !== e.sel) begin
          failures++;
          $display("FAIL sel tag=%0d got=%b want=%b", e.tag, sel, e.sel);
        end
        checks++;
        if (seg !== e.seg) begin
          failures++;
          $display("FAIL seg tag=%0d got=%h want=%h", e.tag, seg, e.seg);
        end
      end
    end
  end

  initial begin
    sel_tab[0] = 6'b011111;
    sel_tab[1] = 6'b101111;
    sel_tab[2] = 6'b110111;
    sel_tab[3] = 6'b111011;
    sel_tab[4] = 6'b111101;
    sel_tab[5] = 6'b111110;
    pats[1] = '{8'hF9, 8'hC0, 8'h40, 8'hA4, 8'h92, 8'h92};
`ifdef SEG_LEAD_ZERO_BLANK_EN
    pats[0] = '{8'hFF, 8'hFF, 8'h40, 8'hFF, 8'hFF, 8'hC0};
    pats[2] = '{8'hF9, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hF8};
    pats[3] = '{8'hFF, 8'hFF, 8'h12, 8'hFF, 8'h99, 8'hC0};
    pats[4] = '{8'hA4, 8'hC0, 8'h40, 8'hFF, 8'h99, 8'hC0};
`else
    pats[0] = '{8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0};
    pats[2] = '{8'hF9, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hF8};
    pats[3] = '{8'hC0, 8'hC0, 8'h12, 8'hC0, 8'h99, 8'hC0};
    pats[4] = '{8'hA4, 8'hC0, 8'h40, 8'hC0, 8'h99, 8'hC0};
`endif

    rst_n = 1'b1;
    addr  = 8'd100;
    data  = 8'd255;
    #1 rst_n = 1'b0;

    // Reset held for 5 cycles, released just after the 5th edge.
    for (int i = 1; i <= 5; i++) begin
      @(posedge sys_clk); #1;
      if (i == 5) rst_n = 1'b1;
      push(6'b111111, 8'hFF, i);
    end

    // k counts rising edges since release. Conversions load at edges
    // 2,12,22,... and publish at 11,21,31,...; seg at edge k reflects the
    // display registers written by edge k-1.
    for (int k = 1; k <= 135; k++) begin
      int p;
      @(posedge sys_clk); #1;
      if (k == 25) data = 8'd7;          // 3rd SHIFT of the conversion loaded at 22
      if (k == 45) begin
        addr = 8'd5;
        data = 8'd40;
      end
      if (k == 130) addr = 8'd200;       // sampled at LOAD on edge 132
      if (k == 135) begin                // mid-SHIFT of the 200 conversion
        rst_n = 1'b0;
        push(6'b111111, 8'hFF, 1000 + k);
      end else begin
        p = (k <= 11) ? 0 : (k <= 41) ? 1 : (k <= 61) ? 2 : 3;
        push_scan(k, p, 1000 + k);
      end
    end

    for (int i = 1; i <= 3; i++) begin
      @(posedge sys_clk); #1;
      if (i == 3) rst_n = 1'b1;
      push(6'b111111, 8'hFF, 2000 + i);
    end

    // After the mid-conversion reset, zeros until the first DONE, then 200/040.
    for (int k = 1; k <= 70; k++) begin
      @(posedge sys_clk); #1;
      push_scan(k, (k <= 11) ? 0 : 4, 3000 + k);
    end

    for (int w = 0; w < 4 && q.size() > 0; w++) @(posedge sys_clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
